// File: rtl/judge_engine.sv
// Multi-lane rhythm judge: per-lane note FIFOs, key edge detect, fixed-priority service,
// PERFECT/GOOD/MISS grading with saturating score/combo. Optional macro: COMBO_BONUS_EN.
module judge_engine #(
  parameter int LANES       = 8,
  parameter int TS_W        = 10,
  parameter int DEPTH       = 4,
  parameter int WIN_PERFECT = 2,
  parameter int WIN_GOOD    = 5,
  parameter int SCORE_W     = 11,
  parameter int PTS_PERFECT = 3,
  parameter int PTS_GOOD    = 1
) (
  input  logic                     CLOCK50M,
  input  logic                     RESET_N,
  input  logic                     clear,
  input  logic [TS_W-1:0]          game_timer,
  input  logic                     note_valid,
  input  logic [$clog2(LANES)-1:0] note_lane,
  input  logic [TS_W-1:0]          note_time,
  output logic                     note_ready,
  input  logic [LANES-1:0]         key_in,
  output logic                     judge_valid,
  output logic [$clog2(LANES)-1:0] judge_lane,
  output logic [1:0]               judge_grade,
  output logic [SCORE_W-1:0]       score,
  output logic [7:0]               combo,
  output logic [7:0]               max_combo
);
  localparam int LW = $clog2(LANES);
  localparam int PW = $clog2(DEPTH);
  localparam logic signed [TS_W-1:0] C_WP  = TS_W'(WIN_PERFECT);
  localparam logic signed [TS_W-1:0] C_WPN = TS_W'(-WIN_PERFECT);
  localparam logic signed [TS_W-1:0] C_WG  = TS_W'(WIN_GOOD);
  localparam logic signed [TS_W-1:0] C_WGN = TS_W'(-WIN_GOOD);
  localparam logic [SCORE_W:0]       C_PP  = (SCORE_W+1)'(PTS_PERFECT);
  localparam logic [SCORE_W:0]       C_PG  = (SCORE_W+1)'(PTS_GOOD);

  logic [LANES-1:0]        r_key_q, r_pend;
  logic [LANES-1:0]        w_empty, w_full, w_expire, w_ev, w_pend_clr;
  logic signed [TS_W-1:0]  w_delta [LANES];
  logic                    w_push, w_pop, w_any, w_hit, w_miss;
  logic                    w_in_good, w_in_perf;
  logic [LW-1:0]           w_win;
  logic signed [TS_W-1:0]  w_win_delta;
  logic [SCORE_W:0]        w_pts, w_sum;
  logic [7:0]              w_combo_inc;

  assign note_ready = !w_full[note_lane];
  assign w_push     = note_valid && note_ready;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [TS_W-1:0] r_mem [DEPTH];
      logic [PW:0]     r_wptr, r_rptr;
      logic [TS_W-1:0] w_head;
      logic            w_lane_push, w_lane_pop;

      assign w_lane_push   = w_push && (note_lane == LW'(gi));
      assign w_lane_pop    = w_pop && (w_win == LW'(gi));
      assign w_head        = r_mem[r_rptr[PW-1:0]];
      // Signed reinterpretation of the modular difference keeps timer wrap correct.
      assign w_delta[gi]   = game_timer - w_head;
      assign w_empty[gi]   = (r_wptr == r_rptr);
      assign w_full[gi]    = (r_wptr[PW-1:0] == r_rptr[PW-1:0]) && (r_wptr[PW] != r_rptr[PW]);
      assign w_expire[gi]  = !w_empty[gi] && (w_delta[gi] > C_WG);
      assign w_ev[gi]      = r_pend[gi] || w_expire[gi];

      always_ff @(posedge CLOCK50M or negedge RESET_N) begin
        if (!RESET_N) begin
          r_wptr <= '0;
          r_rptr <= '0;
        end else if (clear) begin
          r_wptr <= '0;
          r_rptr <= '0;
        end else begin
          if (w_lane_push) r_wptr <= r_wptr + {{PW{1'b0}}, 1'b1};
          if (w_lane_pop)  r_rptr <= r_rptr + {{PW{1'b0}}, 1'b1};
        end
      end

      always_ff @(posedge CLOCK50M) begin
        if (w_lane_push) r_mem[r_wptr[PW-1:0]] <= note_time;
      end
    end
  endgenerate

  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (w_ev[i]) begin
        w_any = 1'b1;
        w_win = LW'(i);
      end
    end
  end

  assign w_win_delta = w_delta[w_win];
  assign w_in_good   = !w_empty[w_win] && (w_win_delta >= C_WGN) && (w_win_delta <= C_WG);
  assign w_in_perf   = !w_empty[w_win] && (w_win_delta >= C_WPN) && (w_win_delta <= C_WP);
  // Expiry outranks a press on the same lane; the press stays pending for the next head.
  assign w_miss      = w_any && w_expire[w_win];
  assign w_hit       = w_any && !w_expire[w_win] && r_pend[w_win] && w_in_good;
  assign w_pop       = w_hit || w_miss;
  assign w_pend_clr  = (w_any && !w_expire[w_win]) ? ({{(LANES-1){1'b0}}, 1'b1} << w_win) : '0;
  assign w_combo_inc = (combo == 8'hFF) ? combo : combo + 8'd1;

  always_comb begin
    w_pts = w_in_perf ? C_PP : C_PG;
`ifdef COMBO_BONUS_EN
    if (combo >= 8'd10) w_pts = w_pts + {{SCORE_W{1'b0}}, 1'b1};
`endif
    w_sum = {1'b0, score} + w_pts;
  end

  always_ff @(posedge CLOCK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_key_q     <= '0;
      r_pend      <= '0;
      judge_valid <= 1'b0;
      judge_lane  <= '0;
      judge_grade <= 2'd0;
      score       <= '0;
      combo       <= 8'd0;
      max_combo   <= 8'd0;
    end else if (clear) begin
      r_key_q     <= '0;
      r_pend      <= '0;
      judge_valid <= 1'b0;
      judge_lane  <= '0;
      judge_grade <= 2'd0;
      score       <= '0;
      combo       <= 8'd0;
      max_combo   <= 8'd0;
    end else begin
      r_key_q     <= key_in;
      r_pend      <= (r_pend & ~w_pend_clr) | (key_in & ~r_key_q);
      judge_valid <= w_pop;
      if (w_pop) begin
        judge_lane  <= w_win;
        judge_grade <= w_miss ? 2'd0 : (w_in_perf ? 2'd2 : 2'd1);
      end
      if (w_miss) begin
        combo <= 8'd0;
      end else if (w_hit) begin
        combo <= w_combo_inc;
        if (w_combo_inc > max_combo) max_combo <= w_combo_inc;
        score <= w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_judge_engine.sv
// Scoreboard bench for judge_engine: directed scenarios plus randomized play against a
// queue-based reference model of the judging rules.
module tb_judge_engine;
  localparam int LANES = 8;
  localparam int TS_W = 10;
  localparam int DEPTH = 4;
  localparam int WP = 2;
  localparam int WG = 5;
  localparam int SMAX = 2047;

  logic       clk = 1'b0;
  logic       RESET_N = 1'b1;
  logic       clear = 1'b0;
  logic [9:0] game_timer = '0;
  logic       note_valid = 1'b0;
  logic [2:0] note_lane = '0;
  logic [9:0] note_time = '0;
  logic       note_ready;
  logic [7:0] key_in = '0;
  logic       judge_valid;
  logic [2:0] judge_lane;
  logic [1:0] judge_grade;
  logic [10:0] score;
  logic [7:0] combo, max_combo;

  judge_engine dut (
    .CLOCK50M(clk), .RESET_N(RESET_N), .clear(clear), .game_timer(game_timer),
    .note_valid(note_valid), .note_lane(note_lane), .note_time(note_time),
    .note_ready(note_ready), .key_in(key_in), .judge_valid(judge_valid),
    .judge_lane(judge_lane), .judge_grade(judge_grade), .score(score),
    .combo(combo), .max_combo(max_combo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int lane; int grade; int score; int combo; int maxc; int due;
  } exp_t;
  exp_t sbq[$];

  // Reference model: each lane is a plain list of queued timestamps.
  int mq [LANES][DEPTH];
  int mcnt [LANES];
  bit mpend [LANES];
  bit mprev [LANES];
  int mscore, mcombo, mmax;

  function automatic int sdelta(input int t, input int h);
    int d;
    d = (t - h) & 1023;
    if (d >= 512) d -= 1024;
    return d;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model_clear();
    for (int l = 0; l < LANES; l++) begin
      mcnt[l] = 0; mpend[l] = 0; mprev[l] = 0;
    end
    mscore = 0; mcombo = 0; mmax = 0;
  endfunction

  function automatic void model_pop(input int l);
    for (int j = 0; j < DEPTH - 1; j++) mq[l][j] = mq[l][j+1];
    mcnt[l]--;
  endfunction

  function automatic void model_step();
    int  win;
    bit  is_exp;
    bit  ready_pre;
    int  d, pts;
    exp_t e;
    if (clear) begin
      model_clear();
      return;
    end
    ready_pre = (mcnt[note_lane] < DEPTH);
    win = -1;
    is_exp = 0;
    for (int l = 0; l < LANES; l++) begin
      bit ex;
      ex = (mcnt[l] > 0) && (sdelta(int'(game_timer), mq[l][0]) > WG);
      if (win < 0 && (mpend[l] || ex)) begin
        win = l;
        is_exp = ex;
      end
    end
    if (win >= 0) begin
      d = (mcnt[win] > 0) ? sdelta(int'(game_timer), mq[win][0]) : 0;
      if (is_exp) begin
        model_pop(win);
        mcombo = 0;
        e = '{win, 0, mscore, mcombo, mmax, cyc + 1};
        sbq.push_back(e);
      end else if (mcnt[win] > 0 && iabs(d) <= WG) begin
        pts = (iabs(d) <= WP) ? 3 : 1;
`ifdef COMBO_BONUS_EN
        if (mcombo >= 10) pts++;
`endif
        mscore = (mscore + pts > SMAX) ? SMAX : mscore + pts;
        mcombo = (mcombo < 255) ? mcombo + 1 : 255;
        if (mcombo > mmax) mmax = mcombo;
        model_pop(win);
        mpend[win] = 0;
        e = '{win, (iabs(d) <= WP) ? 2 : 1, mscore, mcombo, mmax, cyc + 1};
        sbq.push_back(e);
      end else begin
        mpend[win] = 0;
      end
    end
    if (note_valid && ready_pre) begin
      mq[note_lane][mcnt[note_lane]] = int'(note_time);
      mcnt[note_lane]++;
    end
    for (int l = 0; l < LANES; l++) begin
      if (key_in[l] && !mprev[l]) mpend[l] = 1;
      mprev[l] = key_in[l];
    end
  endfunction

  // Monitor: every judgement must match the head of the scoreboard on its due cycle.
  always @(negedge clk) begin
    if (judge_valid) begin
      if (sbq.size() == 0 || sbq[0].due != cyc) begin
        chk("unexpected_judge", 1, 0);
      end else begin
        chk("judge_lane", int'(judge_lane), sbq[0].lane);
        chk("judge_grade", int'(judge_grade), sbq[0].grade);
        chk("judge_score", int'(score), sbq[0].score);
        chk("judge_combo", int'(combo), sbq[0].combo);
        chk("judge_max_combo", int'(max_combo), sbq[0].maxc);
        void'(sbq.pop_front());
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      chk("missing_judge", 0, 1);
      void'(sbq.pop_front());
    end
  end

  // Inputs are set mid-cycle; the model sees exactly what the next rising edge samples.
  task automatic step();
    #1;
    chk("note_ready", int'(note_ready), (mcnt[note_lane] < DEPTH) ? 1 : 0);
    model_step();
    @(posedge clk);
    @(negedge clk);
    #3;
    game_timer = game_timer + 10'd1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_time(input int v);
    while (int'(game_timer) != v) step();
  endtask

  task automatic push(input int lane, input int t);
    note_valid = 1'b1;
    note_lane = 3'(lane);
    note_time = 10'(t);
    step();
    note_valid = 1'b0;
  endtask

  task automatic press(input logic [7:0] mask);
    key_in = key_in | mask;
    step();
    key_in = key_in & ~mask;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    #1;
    chk("rst_judge_valid", int'(judge_valid), 0);
    chk("rst_judge_lane", int'(judge_lane), 0);
    chk("rst_judge_grade", int'(judge_grade), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_combo", int'(combo), 0);
    chk("rst_max_combo", int'(max_combo), 0);
    chk("rst_note_ready", int'(note_ready), 1);
    model_clear();
    sbq.delete();
    @(posedge clk);
    @(negedge clk);
    #3;
    RESET_N = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();

    // Reset mid-stream with a full lane and three notes elsewhere.
    game_timer = 10'd20;
    for (int k = 0; k < 4; k++) push(7, 60 + k);
    for (int k = 0; k < 3; k++) push(2, 70 + k);
    note_lane = 3'd7;
    #1;
    chk("full_before_reset", int'(note_ready), 0);
    do_reset();
    wait_time(70);
    press(8'h04);
    idle(3);
    chk("post_reset_score", int'(score), 0);

    // Timing windows.
    do_clear();
    game_timer = 10'd90;
    push(2, 100);
    wait_time(101);
    press(8'h04);
    idle(3);
    chk("perfect_score", int'(score), 3);
    chk("perfect_combo", int'(combo), 1);
    push(2, 200);
    wait_time(204);
    press(8'h04);
    idle(3);
    chk("good_score", int'(score), 4);
    chk("good_combo", int'(combo), 2);

    // Expiry across timer wrap.
    do_clear();
    game_timer = 10'd1010;
    push(0, 1022);
    wait_time(6);
    idle(2);
    chk("miss_combo", int'(combo), 0);
    chk("miss_max_combo", int'(max_combo), 0);

    // Two lanes pressed in the same cycle.
    do_clear();
    game_timer = 10'd300;
    push(1, 310);
    push(5, 310);
    wait_time(310);
    press(8'h22);
    idle(4);
    chk("contention_score", int'(score), 6);

    // Full lane drop and stray press.
    do_clear();
    game_timer = 10'd400;
    for (int k = 0; k < 4; k++) push(3, 410 + k);
    note_valid = 1'b1;
    note_lane = 3'd3;
    note_time = 10'd414;
    #1;
    chk("full_note_ready", int'(note_ready), 0);
    step();
    note_valid = 1'b0;
    press(8'h40);
    idle(3);
    chk("stray_score", int'(score), 0);
    idle(30);

    // Eleven consecutive PERFECTs.
    do_clear();
    game_timer = 10'd500;
    for (int k = 0; k < 11; k++) begin
      int nt;
      nt = (int'(game_timer) + 4) & 1023;
      push(4, nt);
      wait_time(nt);
      press(8'h10);
      idle(2);
    end
`ifdef COMBO_BONUS_EN
    chk("streak_score", int'(score), 34);
`else
    chk("streak_score", int'(score), 33);
`endif
    chk("streak_max_combo", int'(max_combo), 11);

    // Randomized play.
    do_clear();
    for (int k = 0; k < 3000; k++) begin
      note_valid = ($urandom_range(0, 3) == 0);
      note_lane = 3'($urandom_range(0, LANES - 1));
      note_time = game_timer + 10'($urandom_range(0, 14));
      for (int l = 0; l < LANES; l++)
        if ($urandom_range(0, 9) == 0) key_in[l] = ~key_in[l];
      clear = ($urandom_range(0, 399) == 0);
      step();
    end
    note_valid = 1'b0;
    clear = 1'b0;
    key_in = '0;
    idle(40);

    chk("sb_drained", sbq.size(), 0);
    chk("final_score", int'(score), mscore);
    chk("final_combo", int'(combo), mcombo);
    chk("final_max_combo", int'(max_combo), mmax);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
